// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one GCD datapath between
// NUM_REQ requesters. One job is outstanding at a time. The result is held on
// the owner's response port until that requester accepts it.
module gcd_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*W-1:0]       req_x,
    input  logic [NUM_REQ*W-1:0]       req_y,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [W-1:0]               resp_data,
    output logic                       gcd_in_valid,
    input  logic                       gcd_in_ready,
    output logic [W-1:0]               gcd_x,
    output logic [W-1:0]               gcd_y,
    input  logic [W-1:0]               gcd_out,
    input  logic                       gcd_out_valid,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic [15:0]                jobs_done
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               busy_nxt;
    logic               gcd_in_valid_nxt;
    logic [NUM_REQ-1:0] resp_valid_nxt;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      grant_idx;
    logic [PW-1:0]      cand;
    logic [PW:0]        cand_sum;
    logic               grant_found;
    logic               grant_fire;
    logic               cap_fire;
    logic               done_fire;

    logic [W-1:0]       op_x;
    logic [W-1:0]       op_y;
    logic [W-1:0]       result;
    logic [15:0]        done_cnt;

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (PW+1)'(NUM_REQ);
            end
            cand = PW'(cand_sum);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state logic, accept strobe and next values of the decoded outputs.
    always_comb begin
        state_nxt        = state;
        req_ready        = '0;
        grant_fire       = 1'b0;
        cap_fire         = 1'b0;
        done_fire        = 1'b0;
        busy_nxt         = 1'b0;
        gcd_in_valid_nxt = 1'b0;
        resp_valid_nxt   = '0;
        case (state)
            S_IDLE: begin
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    grant_fire           = 1'b1;
                    state_nxt            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gcd_in_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (gcd_out_valid) begin
                    cap_fire  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready[owner]) begin
                    done_fire = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt         = (state_nxt != S_IDLE);
        gcd_in_valid_nxt = (state_nxt == S_ISSUE);
        if (state_nxt == S_RESP) begin
            resp_valid_nxt[owner] = 1'b1;
        end
    end

    // State register with registered handshake/status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            gcd_in_valid <= 1'b0;
            resp_valid   <= '0;
        end else begin
            state        <= state_nxt;
            busy         <= busy_nxt;
            gcd_in_valid <= gcd_in_valid_nxt;
            resp_valid   <= resp_valid_nxt;
        end
    end

    // Operand/result capture, grant pointer and completed-job counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr      <= '0;
            owner    <= '0;
            op_x     <= '0;
            op_y     <= '0;
            result   <= '0;
            done_cnt <= '0;
        end else begin
            if (grant_fire) begin
                owner <= grant_idx;
                op_x  <= req_x[grant_idx*W +: W];
                op_y  <= req_y[grant_idx*W +: W];
                ptr   <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
            end
            if (cap_fire) begin
                result <= gcd_out;
            end
            if (done_fire) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    assign gcd_x     = op_x;
    assign gcd_y     = op_y;
    assign resp_data = result;
    assign jobs_done = done_cnt;

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one GCD datapath between `NUM_REQ` independent requesters. It accepts one job at a time from the requester ports and drives the GCD `in_valid`/`in_ready` handshake. It waits for the GCD `out_valid` pulse and holds the result on the owning requester's response port until that requester accepts it. It sits between the requester fabric and the single GCD instance, and it also keeps a completed-job counter for test-bench scoreboarding.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..16.
- `W`, default 32: operand and result width. Must match the GCD datapath.

Ports:
- `clock` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester job request.
- `req_ready` out NUM_REQ: one-hot job-accept strobe.
- `req_x` in NUM_REQ*W: packed operand x. Requester i occupies bits [i*W +: W].
- `req_y` in NUM_REQ*W: packed operand y, same packing as `req_x`.
- `resp_valid` out NUM_REQ: one-hot. Result valid for the owning requester.
- `resp_ready` in NUM_REQ: per-requester result accept.
- `resp_data` out W: shared result bus. Meaningful only where `resp_valid` is set.
- `gcd_in_valid` out 1: drives GCD `in_valid`.
- `gcd_in_ready` in 1: from GCD `in_ready`.
- `gcd_x` out W: drives GCD `x`.
- `gcd_y` out W: drives GCD `y`.
- `gcd_out` in W: from GCD `out`.
- `gcd_out_valid` in 1: from GCD `out_valid`. Treated as a single-cycle pulse.
- `owner` out clog2(NUM_REQ): index of the current or last granted requester.
- `busy` out 1: high in any state other than IDLE.
- `jobs_done` out 16: count of completed responses. Wraps modulo 2^16.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. Only one job is ever outstanding.
- Grant pointer `ptr`:
  - Width clog2(NUM_REQ); reset value 0.
  - Search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1. The first requester with `req_valid` wins.
- IDLE:
  - If any `req_valid` is set, assert `req_ready[g]` combinationally for the winner g only.
  - In that cycle, latch `req_x[g]` and `req_y[g]` into operand registers and set `owner` = g.
  - Set `ptr` = (g+1) mod NUM_REQ, then go to ISSUE.
  - If no `req_valid` is set, stay in IDLE.
- ISSUE:
  - `gcd_in_valid`=1, with `gcd_x`/`gcd_y` driven from the operand registers. These stay stable until the handshake completes.
  - On `gcd_in_valid && gcd_in_ready`, go to WAIT.
  - `gcd_out_valid` is ignored in this state.
- WAIT:
  - `gcd_in_valid`=0.
  - On `gcd_out_valid`, capture `gcd_out` into the result register and go to RESP.
  - There is no timeout.
- RESP:
  - `resp_valid[owner]`=1 and `resp_data` = result register.
  - On `resp_ready[owner]`: go to IDLE and increment `jobs_done`.
  - `resp_ready` bits of non-owners are ignored.
  - New requests are not granted until the state returns to IDLE.
- Outside ISSUE, `gcd_x`/`gcd_y` hold the operand registers. In IDLE, `resp_data` holds the last result.
- Arithmetic: no width conversion; operands and result pass through unchanged. `jobs_done` wraps from 16'hFFFF to 0.

## Timing
- Reset values: state=IDLE, `ptr`=0, `owner`=0, `busy`=0, `req_ready`=0, `resp_valid`=0, `gcd_in_valid`=0, `gcd_x`=`gcd_y`=0, `resp_data`=0, `jobs_done`=0.
- Reset mid-operation (any state) aborts the job and returns to the reset values on the next edge. No response is issued. The GCD is reset by the same `reset`.
- Minimum per-job overhead, excluding GCD compute time, is 4 cycles:
  - accept in IDLE → ISSUE (≥1 cycle) → WAIT (≥1 cycle) → RESP (≥1 cycle) → IDLE.
  - `gcd_in_ready` high in the first ISSUE cycle gives exactly 1 ISSUE cycle.
  - `resp_ready` held high gives 1 RESP cycle.
- `req_ready` depends combinationally on `req_valid` and state. All other outputs are registered or decoded from registered state.
- Back-to-back: the cycle after the RESP handshake is IDLE and can grant immediately.
- Requester i must hold `req_valid`, `req_x` and `req_y` stable until `req_ready[i]` is seen.

## Test plan
- Single job: requester 0 sends x=48, y=18. Response: `resp_valid`=4'b0001, `resp_data`=6, `jobs_done`=1, `ptr`=1. There are exactly 4 overhead cycles plus GCD latency.
- Contention: all four requesters are valid from reset, with jobs (12,8), (9,6), (35,21), (17,5). Grants go 0,1,2,3 in order. Results are 4, 3, 7, 1 on the matching `resp_valid` bits.
- Fairness: requesters 1 and 3 hold `req_valid` continuously for 6 jobs. Grants alternate 1,3,1,3,1,3 and requester 0 is never granted.
- Response backpressure: `resp_ready[owner]` is held low for 10 cycles in RESP. `resp_valid` and `resp_data` stay stable, another requester's valid request stays ungranted, and `gcd_in_valid` stays 0.
- Reset mid-WAIT: assert `reset` for 1 cycle while in WAIT on job (100,75). All outputs return to their reset values, no `resp_valid` appears, and the next job (100,75) returns 25.
- Counter wrap: preload via 65535 completed jobs (or force), then complete one more. `jobs_done` reads 0.
